// File: rtl/val2_shift_sequencer.sv
// Multi-cycle barrel-free shifter for register-specified operand-2 shifts.
// Define VAL2_SHIFT_FAST_EN to shift up to 4 bits per SHIFT cycle.
module val2_shift_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  shift_type,
  input  logic [31:0] val_rm,
  input  logic [7:0]  val_rs,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] val2_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_work;
  logic [5:0]  r_cnt;
  logic [1:0]  r_type;
  logic [31:0] r_out;

  logic        w_accept;
  logic [5:0]  w_amt_eff;
  logic [2:0]  w_step_n;
  logic        w_last;
  logic [31:0] w_work_nx;
  logic [5:0]  w_cnt_nx;

  function automatic logic [31:0] f_step(
    input logic [31:0] v,
    input logic [1:0]  t
  );
    logic [31:0] r;
    r = v;
    unique case (t)
      T_LSL: r = {v[30:0], 1'b0};
      T_LSR: r = {1'b0, v[31:1]};
      T_ASR: r = {v[31], v[31:1]};
      T_ROR: r = {v[0], v[31:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign w_accept = (r_state == S_IDLE) && start && !flush;

  // ROR wraps at 32; the linear shifts saturate there.
  always_comb begin
    w_amt_eff = 6'd0;
    if (shift_type == T_ROR)
      w_amt_eff = {1'b0, val_rs[4:0]};
    else if (val_rs >= 8'd32)
      w_amt_eff = 6'd32;
    else
      w_amt_eff = val_rs[5:0];
  end

`ifdef VAL2_SHIFT_FAST_EN
  logic [31:0] w_s1;
  logic [31:0] w_s2;
  logic [31:0] w_s3;
  logic [31:0] w_s4;

  assign w_s1 = f_step(r_work, r_type);
  assign w_s2 = f_step(w_s1, r_type);
  assign w_s3 = f_step(w_s2, r_type);
  assign w_s4 = f_step(w_s3, r_type);

  always_comb begin
    w_step_n = 3'd4;
    if (r_cnt < 6'd4)
      w_step_n = r_cnt[2:0];
  end

  always_comb begin
    w_work_nx = r_work;
    unique case (w_step_n)
      3'd1:    w_work_nx = w_s1;
      3'd2:    w_work_nx = w_s2;
      3'd3:    w_work_nx = w_s3;
      3'd4:    w_work_nx = w_s4;
      default: w_work_nx = r_work;
    endcase
  end
`else
  assign w_step_n  = 3'd1;
  assign w_work_nx = f_step(r_work, r_type);
`endif

  assign w_cnt_nx = r_cnt - {3'b000, w_step_n};
  assign w_last   = (r_cnt <= {3'b000, w_step_n});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start)
            w_next = (w_amt_eff == 6'd0) ? S_DONE : S_SHIFT;
        end
        S_SHIFT: begin
          if (w_last)
            w_next = S_DONE;
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= 32'd0;
      r_cnt  <= 6'd0;
      r_type <= 2'b00;
      r_out  <= 32'd0;
    end else if (flush) begin
      r_cnt <= 6'd0;
    end else if (w_accept) begin
      r_work <= val_rm;
      r_cnt  <= w_amt_eff;
      r_type <= shift_type;
      if (w_amt_eff == 6'd0)
        r_out <= val_rm;
    end else if (r_state == S_SHIFT) begin
      r_work <= w_work_nx;
      r_cnt  <= w_cnt_nx;
      if (w_last)
        r_out <= w_work_nx;
    end
  end

  assign ready    = (r_state == S_IDLE);
  assign busy     = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign done     = (r_state == S_DONE);
  assign val2_out = r_out;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Directed bench for val2_shift_sequencer (base and fast builds).
module tb_val2_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  shift_type;
  logic [31:0] val_rm;
  logic [7:0]  val_rs;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] val2_out;

  int total;
  int bad;

  val2_shift_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flush      (flush),
    .shift_type (shift_type),
    .val_rm     (val_rm),
    .val_rs     (val_rs),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .val2_out   (val2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] t,
                        input logic [31:0] rm, input logic [7:0] rs,
                        input logic [31:0] exp_val, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    start      = 1'b1;
    shift_type = t;
    val_rm     = rm;
    val_rs     = rs;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_val"}, val2_out, exp_val);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {30'd0, done, ready}, 32'd1);
  endtask

  initial begin
    int saw;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    flush      = 1'b0;
    shift_type = 2'b00;
    val_rm     = 32'd0;
    val_rs     = 8'd0;
    #2;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out", val2_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef VAL2_SHIFT_FAST_EN
    run_op("lsl4", 2'b00, 32'h0000_0001, 8'd4, 32'h0000_0010, 2);
    run_op("asr200", 2'b10, 32'h8000_0000, 8'd200, 32'hFFFF_FFFF, 9);
    run_op("ror40", 2'b11, 32'h1234_5678, 8'd40, 32'h7812_3456, 3);
    run_op("ror32", 2'b11, 32'h1234_5678, 8'd32, 32'h1234_5678, 1);
    run_op("lsr0", 2'b01, 32'hFFFF_FFFF, 8'd0, 32'hFFFF_FFFF, 1);
    run_op("lsr31", 2'b01, 32'h8000_0000, 8'd31, 32'h0000_0001, 9);
    run_op("lsl32", 2'b00, 32'hFFFF_FFFF, 8'd32, 32'h0000_0000, 9);
    run_op("asr5", 2'b10, 32'hF000_0000, 8'd5, 32'hFF80_0000, 3);
`else
    run_op("lsl4", 2'b00, 32'h0000_0001, 8'd4, 32'h0000_0010, 5);
    run_op("asr200", 2'b10, 32'h8000_0000, 8'd200, 32'hFFFF_FFFF, 33);
    run_op("ror40", 2'b11, 32'h1234_5678, 8'd40, 32'h7812_3456, 9);
    run_op("ror32", 2'b11, 32'h1234_5678, 8'd32, 32'h1234_5678, 1);
    run_op("lsr0", 2'b01, 32'hFFFF_FFFF, 8'd0, 32'hFFFF_FFFF, 1);
    run_op("lsr31", 2'b01, 32'h8000_0000, 8'd31, 32'h0000_0001, 32);
    run_op("lsl32", 2'b00, 32'hFFFF_FFFF, 8'd32, 32'h0000_0000, 33);
    run_op("asr5", 2'b10, 32'hF000_0000, 8'd5, 32'hFF80_0000, 6);
`endif

    // flush three cycles into an LSL by 20
    @(negedge clk);
    start      = 1'b1;
    shift_type = 2'b00;
    val_rm     = 32'h0000_0001;
    val_rs     = 8'd20;
    @(negedge clk);
    start = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("fl_ready", {31'd0, ready}, 32'd1);
    chk("fl_done", {31'd0, done}, 32'd0);
    chk("fl_out", val2_out, 32'hFF80_0000);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("fl_noacc", {30'd0, busy, ready}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    saw   = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw = 1;
    end
    chk("fl_nodone", saw, 0);
    chk("fl_hold", val2_out, 32'hFF80_0000);

    // start while busy is dropped, not queued
    @(negedge clk);
    start      = 1'b1;
    shift_type = 2'b01;
    val_rm     = 32'h0000_0100;
    val_rs     = 8'd3;
    @(negedge clk);
    shift_type = 2'b00;
    val_rm     = 32'h0000_0003;
    val_rs     = 8'd0;
    @(negedge clk);
    start = 1'b0;
    saw   = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) saw++;
    end
    chk("busy_once", saw, 1);
    chk("busy_val", val2_out, 32'h0000_0020);

    // reset in the middle of a shift
    @(negedge clk);
    start      = 1'b1;
    shift_type = 2'b00;
    val_rm     = 32'h0000_0001;
    val_rs     = 8'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, ready}, 32'd1);
    chk("mr_out", val2_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw   = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw = 1;
    end
    chk("mr_nodone", saw, 0);

`ifdef VAL2_SHIFT_FAST_EN
    run_op("post", 2'b11, 32'h0000_00F1, 8'd4, 32'h1000_000F, 2);
`else
    run_op("post", 2'b11, 32'h0000_00F1, 8'd4, 32'h1000_000F, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/val2_shift_sequencer.md
VAL2_SHIFT_SEQUENCER -- requirements
Module: val2_shift_sequencer

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL provide: start  input  1  request a register-specified shift; sampled only when ready=1.
REQ-004 SHALL provide: flush  input  1  pipeline flush; abandons any operation in progress.
REQ-005 SHALL provide: shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR (Shift_operand[6:5] encoding).
REQ-006 SHALL provide: val_rm  input  32  operand to shift; captured on accept.
REQ-007 SHALL provide: val_rs  input  8  shift amount (Rs[7:0]); captured on accept.
REQ-008 SHALL provide: ready  output  1  1 only in IDLE.
REQ-009 SHALL provide: busy  output  1  1 in SHIFT or DONE; drives the pipeline stall.
REQ-010 SHALL provide: done  output  1  single-cycle pulse; val2_out is valid in that cycle.
REQ-011 SHALL provide: val2_out  output  32  shift result; holds its value until the next accept.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 Accept SHALL occur when the FSM is in IDLE with start=1 and flush=0; accept SHALL latch val_rm into the work register and amt_eff into the counter.
REQ-014 amt_eff SHALL be: ROR -> val_rs[4:0]; LSL/LSR/ASR -> min(val_rs, 32), held in a 6-bit counter.
REQ-015 On accept, the FSM SHALL go to DONE if amt_eff=0, else to SHIFT.
REQ-016 Base build: in SHIFT, each cycle SHALL shift the work register by 1 bit and decrement the counter; the FSM SHALL go to DONE when the counter reaches 1 and that step completes.
REQ-017 Per-bit step SHALL be: LSL zero-fills bit0; LSR zero-fills bit31; ASR replicates bit31; ROR moves bit0 to bit31.
REQ-018 Results SHALL match these rules: LSL/LSR by >=32 -> 0; ASR by >=32 -> 32 copies of val_rm[31]; ROR by a multiple of 32 -> val_rm.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start is not accepted during DONE.
REQ-020 Latency from the accept edge to done SHALL be 1 + number of SHIFT cycles (base build: 1 + amt_eff).
REQ-021 Flush SHALL have priority over everything: in any state, the FSM SHALL go to IDLE next cycle with no done pulse, and val2_out keeps its last completed value.
REQ-022 Start asserted while busy SHALL be ignored and SHALL not be queued.
REQ-023 val2_out SHALL update only on entry to DONE.

Reset
REQ-024 While rst_n=0, the block SHALL be in IDLE with ready=1, busy=0, done=0, val2_out=0, counter=0 and work register=0, regardless of clk.
REQ-025 Reset asserted mid-operation SHALL discard that operation; no done pulse SHALL follow reset release.
REQ-026 The first accept SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-027 Macro VAL2_SHIFT_FAST_EN SHALL select the shift rate.
REQ-028 With VAL2_SHIFT_FAST_EN defined, each SHIFT cycle SHALL shift by min(4, counter) bits, giving ceil(amt_eff/4) SHIFT cycles.
REQ-029 Without VAL2_SHIFT_FAST_EN, each SHIFT cycle SHALL shift by 1 bit (REQ-016).
REQ-030 Results and all other behaviour SHALL be identical in both builds; only latency differs.

Verification
REQ-031 Bench SHALL cover: LSL, val_rm=0x0000_0001, val_rs=4 -> val2_out=0x0000_0010; done 5 cycles after accept (base), 2 cycles (FAST).
REQ-032 Bench SHALL cover: ASR, val_rm=0x8000_0000, val_rs=200 -> val2_out=0xFFFF_FFFF; done 33 cycles after accept (base), 9 cycles (FAST).
REQ-033 Bench SHALL cover: ROR, val_rm=0x1234_5678, val_rs=40 (amount 8) -> val2_out=0x7812_3456; a second ROR with val_rs=32 -> 0x1234_5678, done 1 cycle after accept.
REQ-034 Bench SHALL cover: LSR, val_rm=0xFFFF_FFFF, val_rs=0 -> done 1 cycle after accept, val2_out=0xFFFF_FFFF.
REQ-035 Bench SHALL cover: flush 3 cycles into an LSL by 20 -> no done, ready=1 next cycle, val2_out unchanged; then start in the same cycle as flush -> not accepted.
REQ-036 Bench SHALL cover: rst_n low mid-SHIFT -> busy=0, val2_out=0 immediately without a clock edge; no done after release.
